// File: rtl/multicycle_controller.sv
// Moore control FSM for a shared-memory multicycle MIPS datapath, with memory ready
// handshake and retired-instruction counter. Define MULTICYCLE_ADDI_EN to enable addi.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        regDst,
  output logic        memToReg,
  output logic        regWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALU_controls,
  output logic [1:0]  PCSrc,
  output logic        PCEn,
  output logic        illegalOp,
  output logic [3:0]  stateOut,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      state;
  state_t      next_state;
  logic        retire_now;
  logic        decode_illegal;
  logic        funct_ok;
  logic [2:0]  funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Next-state and retire decision; unused encodings fall back to FETCH.
  always_comb begin
    next_state     = S_FETCH;
    retire_now     = 1'b0;
    decode_illegal = 1'b0;
    case (state)
      S_FETCH:  next_state = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE: begin
            if (funct_ok) next_state = S_EXECUTE;
            else          decode_illegal = 1'b1;
          end
          OP_BEQ: next_state = S_BRANCH;
          OP_J:   next_state = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI: next_state = S_ADDIEX;
`endif
          default: decode_illegal = 1'b1;
        endcase
      end
      S_MEMADR:  next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_state = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   retire_now = 1'b1;
      S_MEMWR: begin
        next_state = memReady ? S_FETCH : S_MEMWR;
        retire_now = memReady;
      end
      S_EXECUTE: next_state = S_ALUWB;
      S_ALUWB:   retire_now = 1'b1;
      S_BRANCH:  retire_now = 1'b1;
      S_JUMP:    retire_now = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX:  next_state = S_ADDIWB;
      S_ADDIWB:  retire_now = 1'b1;
`endif
      default:   next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      retired <= 32'd0;
    end else begin
      state <= next_state;
      if (retire_now) retired <= retired + 32'd1;
    end
  end

  assign stateOut = state;

  // Reset gates every control so no request or strobe escapes during reset.
  always_comb begin
    memReq       = 1'b0;
    memWrite     = 1'b0;
    IorD         = 1'b0;
    IRWrite      = 1'b0;
    regDst       = 1'b0;
    memToReg     = 1'b0;
    regWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALU_controls = 3'b000;
    PCSrc        = 2'b00;
    PCEn         = 1'b0;
    illegalOp    = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          memReq       = 1'b1;
          ALUSrcB      = 2'b01;
          ALU_controls = 3'b010;
          IRWrite      = memReady;
          PCEn         = memReady;
        end
        S_DECODE: begin
          ALUSrcB      = 2'b11;
          ALU_controls = 3'b010;
          illegalOp    = decode_illegal;
        end
        S_MEMADR, S_ADDIEX: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'b10;
          ALU_controls = 3'b010;
        end
        S_MEMRD: begin
          memReq = 1'b1;
          IorD   = 1'b1;
        end
        S_MEMWB: begin
          memToReg = 1'b1;
          regWrite = 1'b1;
        end
        S_MEMWR: begin
          memReq   = 1'b1;
          memWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA      = 1'b1;
          ALU_controls = funct_alu;
        end
        S_ALUWB: begin
          regDst   = 1'b1;
          regWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA      = 1'b1;
          ALU_controls = 3'b110;
          PCSrc        = 2'b01;
          PCEn         = zero;
        end
        S_ADDIWB: regWrite = 1'b1;
        S_JUMP: begin
          PCSrc = 2'b10;
          PCEn  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller: per-instruction state paths
// and control words are derived from the instruction mix and a state-indexed control table.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  Opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        memReady = 1'b1;
  logic        memReq, memWrite, IorD, IRWrite, regDst, memToReg, regWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALU_controls;
  logic        PCEn, illegalOp;
  logic [3:0]  stateOut;
  logic [31:0] retired;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .funct(funct), .zero(zero),
    .memReady(memReady), .memReq(memReq), .memWrite(memWrite), .IorD(IorD),
    .IRWrite(IRWrite), .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_controls(ALU_controls), .PCSrc(PCSrc),
    .PCEn(PCEn), .illegalOp(illegalOp), .stateOut(stateOut), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_RBAD = 3, K_BEQ = 4, K_J = 5, K_ADDI = 6, K_BADOP = 7;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_retired = 32'd0;
  logic [16:0] dut_ctrl;

  assign dut_ctrl = {memReq, memWrite, IorD, IRWrite, regDst, memToReg, regWrite, ALUSrcA,
                     ALUSrcB, ALU_controls, PCSrc, PCEn, illegalOp};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic legal_funct(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 || f == 6'b101010;
  endfunction

  // Control word each state should present, straight from the state/output table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic rdy, input logic z,
                                           input logic ill, input logic [5:0] f);
    logic mrq, mwr, iord, irw, rdst, m2r, rw, sa, pce, il;
    logic [1:0] sb, pcs;
    logic [2:0] alu;
    {mrq, mwr, iord, irw, rdst, m2r, rw, sa, pce, il} = 10'd0;
    sb = 2'b00; pcs = 2'b00; alu = 3'b000;
    case (st)
      0:  begin mrq = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pce = rdy; end
      1:  begin sb = 2'b11; alu = 3'b010; il = ill; end
      2, 9: begin sa = 1; sb = 2'b10; alu = 3'b010; end
      3:  begin mrq = 1; iord = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mrq = 1; mwr = 1; iord = 1; end
      6:  begin sa = 1; alu = alu_of(f); end
      7:  begin rdst = 1; rw = 1; end
      8:  begin sa = 1; alu = 3'b110; pcs = 2'b01; pce = z; end
      10: rw = 1;
      11: begin pcs = 2'b10; pce = 1; end
      default: ;
    endcase
    return {mrq, mwr, iord, irw, rdst, m2r, rw, sa, sb, alu, pcs, pce, il};
  endfunction

  task automatic run_cycle(input int st, input logic rdy, input logic z, input logic ill,
                           input logic chk_ret, input string tag);
    memReady = rdy;
    zero = z;
    @(negedge clk);
    check_val({tag, "/state"}, {28'd0, stateOut}, st);
    check_val({tag, "/ctrl"}, {15'd0, dut_ctrl}, {15'd0, exp_ctrl(st, rdy, z, ill, funct)});
    if (chk_ret) check_val({tag, "/retired"}, retired, exp_retired);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int kind, input int fw, input int mw, input logic z,
                           input logic [5:0] f_in, input string tag);
    int   path[$];
    logic rdys[$];
    logic ill;
    logic addi_ok;
`ifdef MULTICYCLE_ADDI_EN
    addi_ok = 1'b1;
`else
    addi_ok = 1'b0;
`endif
    ill = 1'b0;
    funct = $urandom_range(0, 63);
    case (kind)
      K_LW:  Opcode = 6'b100011;
      K_SW:  Opcode = 6'b101011;
      K_R, K_RBAD: begin Opcode = 6'b000000; funct = f_in; ill = !legal_funct(f_in); end
      K_BEQ: Opcode = 6'b000100;
      K_J:   Opcode = 6'b000010;
      K_ADDI: begin Opcode = 6'b001000; ill = !addi_ok; end
      default: begin Opcode = f_in; ill = 1'b1; end
    endcase
    for (int i = 0; i < fw; i++) begin path.push_back(0); rdys.push_back(1'b0); end
    path.push_back(0); rdys.push_back(1'b1);
    path.push_back(1); rdys.push_back(1'($urandom));
    if (!ill) begin
      case (kind)
        K_LW, K_SW: begin
          path.push_back(2); rdys.push_back(1'($urandom));
          for (int i = 0; i < mw; i++) begin
            path.push_back(kind == K_LW ? 3 : 5); rdys.push_back(1'b0);
          end
          path.push_back(kind == K_LW ? 3 : 5); rdys.push_back(1'b1);
          if (kind == K_LW) begin path.push_back(4); rdys.push_back(1'($urandom)); end
        end
        K_R:    begin path.push_back(6); path.push_back(7); rdys.push_back(1'($urandom)); rdys.push_back(1'($urandom)); end
        K_BEQ:  begin path.push_back(8); rdys.push_back(1'($urandom)); end
        K_J:    begin path.push_back(11); rdys.push_back(1'($urandom)); end
        K_ADDI: begin path.push_back(9); path.push_back(10); rdys.push_back(1'($urandom)); rdys.push_back(1'($urandom)); end
        default: ;
      endcase
    end
    foreach (path[i])
      run_cycle(path[i], rdys[i], (path[i] == 8) ? z : 1'($urandom), ill, i == 0, tag);
    if (!ill) exp_retired = exp_retired + 32'd1;
    $display("instr %s kind=%0d op=%b funct=%b cycles=%0d illegal=%0d retired_exp=%0d",
             tag, kind, Opcode, funct, path.size(), ill, exp_retired);
  endtask

  function automatic logic [5:0] bad_funct();
    logic [5:0] f;
    do f = 6'($urandom_range(0, 63)); while (legal_funct(f));
    return f;
  endfunction

  function automatic logic [5:0] bad_opcode();
    logic [5:0] o;
    do o = 6'($urandom_range(0, 63));
    while (o == 6'b100011 || o == 6'b101011 || o == 6'b000000 || o == 6'b000100 ||
           o == 6'b000010 || o == 6'b001000);
    return o;
  endfunction

  initial begin
    logic [5:0] legal_f[5];
    legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    #1;
    // Reset held low with memReady high: everything quiet.
    for (int i = 0; i < 3; i++) begin
      memReady = 1'b1;
      @(negedge clk);
      check_val("reset/ctrl", {15'd0, dut_ctrl}, 32'd0);
      check_val("reset/state", {28'd0, stateOut}, 32'd0);
      check_val("reset/retired", retired, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;

    run_instr(K_LW, 0, 0, 1'b0, 6'd0, "lw");
    run_instr(K_SW, 0, 2, 1'b0, 6'd0, "sw_wait2");
    run_instr(K_BEQ, 0, 0, 1'b1, 6'd0, "beq_taken");
    run_instr(K_BEQ, 0, 0, 1'b0, 6'd0, "beq_not");
    run_instr(K_R, 0, 0, 1'b0, 6'b101010, "r_slt");
    run_instr(K_RBAD, 0, 0, 1'b0, 6'b000111, "r_bad");
    run_instr(K_ADDI, 0, 0, 1'b0, 6'd0, "addi");
    run_instr(K_J, 1, 0, 1'b0, 6'd0, "j_fwait");

    for (int n = 0; n < 60; n++) begin
      int k;
      logic [5:0] f;
      k = $urandom_range(0, 7);
      case (k)
        K_R:     f = legal_f[$urandom_range(0, 4)];
        K_RBAD:  f = bad_funct();
        K_BADOP: f = bad_opcode();
        default: f = 6'd0;
      endcase
      run_instr(k, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), f, "rand");
    end

    // Reset asserted in the middle of a store that is waiting on memory.
    Opcode = 6'b101011;
    run_cycle(0, 1'b1, 1'b0, 1'b0, 1'b1, "midrst");
    run_cycle(1, 1'b0, 1'b0, 1'b0, 1'b0, "midrst");
    run_cycle(2, 1'b0, 1'b0, 1'b0, 1'b0, "midrst");
    run_cycle(5, 1'b0, 1'b0, 1'b0, 1'b0, "midrst");
    reset = 1'b0;
    memReady = 1'b1;
    @(negedge clk);
    check_val("midrst/ctrl", {15'd0, dut_ctrl}, 32'd0);
    check_val("midrst/state", {28'd0, stateOut}, 32'd0);
    check_val("midrst/retired", retired, 32'd0);
    $display("midrst reset asserted during MEMWR");
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_retired = 32'd0;
    run_instr(K_LW, 0, 1, 1'b0, 6'd0, "lw_after_rst");
    run_instr(K_R, 0, 0, 1'b0, 6'b100010, "r_sub");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences a shared-memory multicycle MIPS datapath: one memory port for instruction and data, one ALU reused for PC increment, branch target and execute. It sits beside the datapath, taking opcode and funct from the instruction register and the ALU zero flag, and driving every mux select, write enable and memory request. It adds a memory ready handshake and a retired-instruction counter for bring-up.

## Interface
- No parameters; opcode/funct widths fixed by the ISA.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Opcode  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0] from instruction register.
- zero  in  1  ALU zero flag.
- memReady  in  1  memory completes the current access this cycle.
- memReq  out  1  memory access request.
- memWrite  out  1  write strobe, only valid with memReq.
- IorD  out  1  address select: 0 PC, 1 ALUOut.
- IRWrite  out  1  load instruction register.
- regDst  out  1  write register: 0 rt, 1 rd.
- memToReg  out  1  write data: 0 ALUOut, 1 data register.
- regWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 PC, 1 register A.
- ALUSrcB  out  2  00 B, 01 const 4, 10 signImm, 11 signImm<<2.
- ALU_controls  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- PCEn  out  1  PC load enable.
- illegalOp  out  1  one-cycle pulse on unsupported instruction.
- stateOut  out  4  current state encoding.
- retired  out  32  count of completed instructions.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; 12-15 unreachable, recover to FETCH.
- FETCH: memReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00; IRWrite=PCEn=memReady; holds until memReady, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target to ALUOut). Opcode 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; anything else, or R-type funct not in {100000,100010,100100,100101,101010} -> illegalOp=1, next FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add; lw -> MEMRD, sw -> MEMWR.
- MEMRD: memReq=1, IorD=1; waits for memReady, then MEMWB. MEMWB: regDst=0, memToReg=1, regWrite=1 -> FETCH.
- MEMWR: memReq=1, memWrite=1, IorD=1; waits for memReady, then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALU_controls from funct (add 010, sub 110, and 000, or 001, slt 111) -> ALUWB. ALUWB: regDst=1, memToReg=0, regWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCEn=zero -> FETCH.
- JUMP: PCSrc=10, PCEn=1 -> FETCH.
- Unlisted outputs are 0 in every state (selects 0, strobes 0).
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWR (on memReady), ALUWB, BRANCH, JUMP, ADDIWB; not on illegal decode; wraps 0xFFFFFFFF -> 0.

## Timing
- All outputs combinational from state, plus memReady (IRWrite, PCEn in FETCH) and zero (PCEn in BRANCH).
- Zero-wait cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each memReady-low cycle in FETCH/MEMRD/MEMWR adds one.
- reset low: state=FETCH, retired=0, all outputs 0 including memReq (forced while reset low); first fetch request in the cycle reset deasserts.
- Reset mid-access: request dropped immediately; no write, no retire; restart at FETCH.
- memReady outside FETCH/MEMRD/MEMWR ignored.

## Configuration
- MULTICYCLE_ADDI_EN defined: opcode 001000 -> ADDIEX (ALUSrcA=1, ALUSrcB=10, add) -> ADDIWB (regDst=0, memToReg=0, regWrite=1) -> FETCH.
- Undefined: ADDIEX/ADDIWB absent; 001000 decodes as illegal (illegalOp pulse, no retire).

## Test plan
- Reset low 3 cycles with memReady=1 -> all outputs 0, stateOut=0; release -> memReq=1, IRWrite=PCEn=1 same cycle.
- lw (opcode 100011), memReady=1 -> states 0,1,2,3,4,0; regWrite=1, memToReg=1 only in state 4; retired=1.
- sw with memReady low 2 cycles in MEMWR -> memWrite held 3 cycles, 6 total cycles, retired +1.
- beq with zero=1 then zero=0 -> PCEn=1 with PCSrc=01 first, PCEn=0 second; 3 cycles each.
- R-type funct 101010 -> ALU_controls=111 in EXECUTE; funct 000111 -> illegalOp pulse in DECODE, retired unchanged.
- addi: with MULTICYCLE_ADDI_EN -> states 0,1,9,10,0, regDst=0 write; without -> illegalOp=1, back to FETCH.
